// File: rtl/mmio_memory_controller.sv
// CPU-to-SRAM memory controller with a memory-mapped keyboard/display I/O page.
// Optional macro KB_INTERRUPT_EN enables the keyboard interrupt (KBSR[14], KB_INT).
module mmio_memory_controller #(
    parameter int                DATA_W        = 16,
    parameter int                ADDR_W        = 16,
    parameter int                SRAM_ADDR_W   = 20,
    parameter int                WAIT_STATES   = 1,
    parameter int                KB_FIFO_DEPTH = 8,
    parameter logic [ADDR_W-1:0] IO_BASE       = 16'hFE00
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   MIO_EN,
    input  logic                   R_W,
    input  logic [ADDR_W-1:0]      Address,
    input  logic [DATA_W-1:0]      Data_FromCPU,
    output logic [DATA_W-1:0]      Data_ToCPU,
    output logic                   MEM_R,
    input  logic                   KB_Valid,
    input  logic [7:0]             KB_Data,
    output logic [DATA_W-1:0]      Data_ToVideo,
    output logic                   Video_Valid,
    input  logic                   Video_Ready,
    output logic                   KB_INT,
    output logic                   SRAM_CE_N,
    output logic                   SRAM_OE_N,
    output logic                   SRAM_WE_N,
    output logic                   SRAM_LB_N,
    output logic                   SRAM_UB_N,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    inout  wire  [DATA_W-1:0]      SRAM_DQ
);

    typedef enum logic [1:0] {IDLE, IO, SRAM_ACC, DONE} state_t;

    localparam int         PTR_W     = $clog2(KB_FIFO_DEPTH);
    localparam logic [2:0] LAST_WAIT = 3'(WAIT_STATES);
    localparam logic [1:0] OFF_KBSR  = 2'd0;
    localparam logic [1:0] OFF_KBDR  = 2'd1;
    localparam logic [1:0] OFF_DSR   = 2'd2;
    localparam logic [1:0] OFF_DDR   = 2'd3;

    state_t              state, state_next;
    logic                rearm, accept, is_io;
    logic [ADDR_W-1:0]   io_off, addr_q;
    logic                rw_q, io_rd, io_wr, sram_drive;
    logic [DATA_W-1:0]   wdata_q, rdata_q, io_rdata, ddr_q;
    logic [1:0]          reg_sel;
    logic [2:0]          wait_cnt;
    logic                video_valid, ddr_load;

    logic [7:0]          kb_mem [KB_FIFO_DEPTH];
    logic [PTR_W-1:0]    kb_wr_ptr, kb_rd_ptr;
    logic [PTR_W:0]      kb_count;
    logic                kb_empty, kb_full, kb_push, kb_pop, kb_ovr, kb_ie;

    // Only even offsets +0..+6 are registers; everything else falls through to SRAM.
    assign io_off = Address - IO_BASE;
    assign is_io  = (Address >= IO_BASE) && (io_off <= ADDR_W'(6)) && !io_off[0];
    assign accept = (state == IDLE) && MIO_EN && rearm;

    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (accept) state_next = is_io ? IO : SRAM_ACC;
            IO:       state_next = IDLE;
            SRAM_ACC: if (wait_cnt == LAST_WAIT) state_next = DONE;
            DONE:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        MEM_R      = 1'b0;
        Data_ToCPU = rdata_q;
        SRAM_CE_N  = 1'b1;
        SRAM_OE_N  = 1'b1;
        SRAM_WE_N  = 1'b1;
        SRAM_LB_N  = 1'b1;
        SRAM_UB_N  = 1'b1;
        sram_drive = 1'b0;
        case (state)
            IO: begin
                MEM_R      = 1'b1;
                Data_ToCPU = io_rdata;
            end
            SRAM_ACC: begin
                SRAM_CE_N  = 1'b0;
                SRAM_LB_N  = 1'b0;
                SRAM_UB_N  = 1'b0;
                SRAM_OE_N  = rw_q;
                SRAM_WE_N  = !rw_q;
                sram_drive = rw_q;
            end
            DONE:    MEM_R = 1'b1;
            default: ;
        endcase
    end

    assign SRAM_DQ   = sram_drive ? wdata_q : {DATA_W{1'bz}};
    assign SRAM_ADDR = SRAM_ADDR_W'(addr_q);

    assign io_rd    = (state == IO) && !rw_q;
    assign io_wr    = (state == IO) && rw_q;
    assign kb_empty = (kb_count == '0);
    assign kb_full  = (kb_count == (PTR_W+1)'(KB_FIFO_DEPTH));
    assign kb_pop   = io_rd && (reg_sel == OFF_KBDR) && !kb_empty;
    assign kb_push  = KB_Valid && (!kb_full || kb_pop);
    assign ddr_load = io_wr && (reg_sel == OFF_DDR) && (!video_valid || Video_Ready);

    always_comb begin
        io_rdata = '0;
        case (reg_sel)
            OFF_KBSR: begin
                io_rdata[15] = !kb_empty;
                io_rdata[14] = kb_ie;
                io_rdata[0]  = kb_ovr;
            end
            OFF_KBDR: if (!kb_empty) io_rdata[7:0] = kb_mem[kb_rd_ptr];
            OFF_DSR:  io_rdata[15] = !video_valid;
            default:  ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rearm    <= 1'b1;
            addr_q   <= '0;
            rw_q     <= 1'b0;
            wdata_q  <= '0;
            reg_sel  <= '0;
            wait_cnt <= '0;
            rdata_q  <= '0;
        end else begin
            // A request held across MEM_R must drop before it can be serviced again.
            if (MEM_R)        rearm <= 1'b0;
            else if (!MIO_EN) rearm <= 1'b1;
            if (accept) begin
                addr_q   <= Address;
                rw_q     <= R_W;
                wdata_q  <= Data_FromCPU;
                reg_sel  <= io_off[2:1];
                wait_cnt <= '0;
            end else if (state == SRAM_ACC) begin
                wait_cnt <= wait_cnt + 3'd1;
            end
            if (state == SRAM_ACC && wait_cnt == LAST_WAIT && !rw_q) rdata_q <= SRAM_DQ;
            if (io_rd) rdata_q <= io_rdata;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            kb_wr_ptr <= '0;
            kb_rd_ptr <= '0;
            kb_count  <= '0;
            kb_ovr    <= 1'b0;
        end else begin
            if (kb_push) kb_wr_ptr <= kb_wr_ptr + PTR_W'(1);
            if (kb_pop)  kb_rd_ptr <= kb_rd_ptr + PTR_W'(1);
            if (kb_push && !kb_pop)      kb_count <= kb_count + (PTR_W+1)'(1);
            else if (kb_pop && !kb_push) kb_count <= kb_count - (PTR_W+1)'(1);
            if (KB_Valid && !kb_push)                     kb_ovr <= 1'b1;
            else if (io_wr && reg_sel == OFF_KBSR)        kb_ovr <= 1'b0;
        end
    end

    // NOTE: the FIFO storage has no reset; validity is tracked entirely by the pointers and count.
    always_ff @(posedge Clk) begin
        if (kb_push) kb_mem[kb_wr_ptr] <= KB_Data;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            video_valid <= 1'b0;
            ddr_q       <= '0;
        end else if (ddr_load) begin
            ddr_q       <= wdata_q;
            video_valid <= 1'b1;
        end else if (video_valid && Video_Ready) begin
            video_valid <= 1'b0;
        end
    end

    assign Data_ToVideo = ddr_q;
    assign Video_Valid  = video_valid;

`ifdef KB_INTERRUPT_EN
    logic kb_int_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            kb_ie    <= 1'b0;
            kb_int_q <= 1'b0;
        end else begin
            if (io_wr && reg_sel == OFF_KBSR) kb_ie <= wdata_q[14];
            kb_int_q <= kb_ie && !kb_empty;
        end
    end

    assign KB_INT = kb_int_q;
`else
    assign kb_ie  = 1'b0;
    assign KB_INT = 1'b0;
`endif

endmodule

// File: tb/tb_mmio_memory_controller.sv
// Scoreboard bench for mmio_memory_controller: accesses push expected read data, a
// negedge monitor pops and compares on every MEM_R pulse.
module tb_mmio_memory_controller;

    logic        Clk = 1'b0;
    logic        Reset, MIO_EN, R_W, KB_Valid, Video_Ready;
    logic [15:0] Address, Data_FromCPU;
    logic [7:0]  KB_Data;
    logic [15:0] Data_ToCPU, Data_ToVideo;
    logic        MEM_R, Video_Valid, KB_INT;
    logic        SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_LB_N, SRAM_UB_N;
    logic [19:0] SRAM_ADDR;
    wire  [15:0] sram_dq;

    typedef struct {
        logic        chk;
        logic [15:0] data;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    int          tests = 0;
    int          fails = 0;
    int          mem_r_seen = 0;
    int          we_cycles = 0;
    logic [19:0] last_sram_addr = '0;
    logic [15:0] sram_mem [0:255];
    logic        sram_oe;

    mmio_memory_controller dut (
        .Clk(Clk), .Reset(Reset), .MIO_EN(MIO_EN), .R_W(R_W), .Address(Address),
        .Data_FromCPU(Data_FromCPU), .Data_ToCPU(Data_ToCPU), .MEM_R(MEM_R),
        .KB_Valid(KB_Valid), .KB_Data(KB_Data), .Data_ToVideo(Data_ToVideo),
        .Video_Valid(Video_Valid), .Video_Ready(Video_Ready), .KB_INT(KB_INT),
        .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N), .SRAM_WE_N(SRAM_WE_N),
        .SRAM_LB_N(SRAM_LB_N), .SRAM_UB_N(SRAM_UB_N), .SRAM_ADDR(SRAM_ADDR),
        .SRAM_DQ(sram_dq)
    );

    always #5 Clk = ~Clk;

    // Behavioural SRAM: only the low address byte is decoded, enough for the addresses used.
    assign sram_oe = !SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N;
    assign sram_dq = sram_oe ? sram_mem[SRAM_ADDR[7:0]] : 16'hzzzz;
    always @(posedge Clk) if (!SRAM_CE_N && !SRAM_WE_N) sram_mem[SRAM_ADDR[7:0]] <= sram_dq;

    always @(negedge Clk) begin
        if (SRAM_WE_N === 1'b0) we_cycles++;
        if (SRAM_CE_N === 1'b0) last_sram_addr = SRAM_ADDR;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    always @(negedge Clk) begin : monitor
        exp_t e;
        if (!Reset && MEM_R === 1'b1) begin
            mem_r_seen++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_mem_r: got MEM_R=1 expected no access pending");
            end else begin
                e = exp_q.pop_front();
                if (e.chk) check(e.name, 32'(Data_ToCPU), 32'(e.data));
            end
        end
    end

    task automatic cpu_access(input logic w, input logic [15:0] addr, input logic [15:0] wd,
                              input logic chk, input logic [15:0] exp_data,
                              input string name, input int exp_lat);
        int lat;
        lat = 0;
        exp_q.push_back('{chk, exp_data, name});
        @(negedge Clk);
        MIO_EN = 1'b1; R_W = w; Address = addr; Data_FromCPU = wd;
        for (int k = 1; k <= 40; k++) begin
            @(posedge Clk); #1;
            if (MEM_R === 1'b1) begin
                lat = k;
                break;
            end
        end
        if (lat == 0) void'(exp_q.pop_back());
        check({name, "_latency"}, lat, exp_lat);
        @(negedge Clk);
        MIO_EN = 1'b0; R_W = 1'b0;
        @(negedge Clk);
    endtask

    task automatic kb_push(input logic [7:0] b);
        KB_Valid = 1'b1; KB_Data = b;
        @(negedge Clk);
        KB_Valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int          base;
        logic [15:0] kbsr_ie_exp;
        logic        kb_int_exp;

        Reset = 1'b1; MIO_EN = 1'b0; R_W = 1'b0; Address = '0; Data_FromCPU = '0;
        KB_Valid = 1'b0; KB_Data = '0; Video_Ready = 1'b0;
        repeat (3) @(negedge Clk);
        check("reset_mem_r", MEM_R, 1'b0);
        check("reset_data_to_cpu", Data_ToCPU, 16'h0000);
        check("reset_video_valid", Video_Valid, 1'b0);
        check("reset_data_to_video", Data_ToVideo, 16'h0000);
        check("reset_kb_int", KB_INT, 1'b0);
        check("reset_sram_ctl_n", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_LB_N, SRAM_UB_N}, 5'b11111);
        Reset = 1'b0;

        // SRAM write then read with one wait state: MEM_R three cycles after accept.
        we_cycles = 0;
        cpu_access(1'b1, 16'h3000, 16'hBEEF, 1'b0, 16'h0, "sram_wr_3000", 3);
        check("sram_we_low_cycles", we_cycles, 2);
        check("sram_addr_3000", last_sram_addr, 20'h03000);
        cpu_access(1'b0, 16'h3000, 16'h0, 1'b1, 16'hBEEF, "sram_rd_3000", 3);

        // Odd / out-of-page offsets fall through to SRAM.
        cpu_access(1'b1, 16'hFE08, 16'h1234, 1'b0, 16'h0, "sram_wr_fe08", 3);
        check("sram_addr_fe08", last_sram_addr, 20'h0FE08);
        cpu_access(1'b0, 16'hFE08, 16'h0, 1'b1, 16'h1234, "sram_rd_fe08", 3);
        cpu_access(1'b0, 16'hFE01, 16'h0, 1'b0, 16'h0, "sram_rd_fe01", 3);

        // Keyboard FIFO basic order.
        kb_push(8'h41);
        kb_push(8'h42);
        cpu_access(1'b0, 16'hFE00, 16'h0, 1'b1, 16'h8000, "kbsr_two", 1);
        cpu_access(1'b0, 16'hFE02, 16'h0, 1'b1, 16'h0041, "kbdr_a", 1);
        cpu_access(1'b0, 16'hFE02, 16'h0, 1'b1, 16'h0042, "kbdr_b", 1);
        cpu_access(1'b0, 16'hFE00, 16'h0, 1'b1, 16'h0000, "kbsr_empty", 1);
        cpu_access(1'b0, 16'hFE02, 16'h0, 1'b1, 16'h0000, "kbdr_empty", 1);

        // Overrun: ninth byte dropped, sticky flag cleared by any KBSR write.
        for (int i = 0; i < 9; i++) kb_push(8'(8'h30 + i));
        cpu_access(1'b0, 16'hFE00, 16'h0, 1'b1, 16'h8001, "kbsr_overrun", 1);
        cpu_access(1'b1, 16'hFE00, 16'h0000, 1'b0, 16'h0, "kbsr_clear", 1);
        cpu_access(1'b0, 16'hFE00, 16'h0, 1'b1, 16'h8000, "kbsr_cleared", 1);
        for (int i = 0; i < 8; i++)
            cpu_access(1'b0, 16'hFE02, 16'h0, 1'b1, 16'(16'h0030 + i), "kbdr_fifo", 1);
        cpu_access(1'b0, 16'hFE00, 16'h0, 1'b1, 16'h0000, "kbsr_drained", 1);

        // Display channel: second write while busy is dropped.
        cpu_access(1'b0, 16'hFE04, 16'h0, 1'b1, 16'h8000, "dsr_idle", 1);
        cpu_access(1'b1, 16'hFE06, 16'h0058, 1'b0, 16'h0, "ddr_wr_58", 1);
        check("video_valid_set", Video_Valid, 1'b1);
        cpu_access(1'b1, 16'hFE06, 16'h0059, 1'b0, 16'h0, "ddr_wr_59", 1);
        check("ddr_kept_58", Data_ToVideo, 16'h0058);
        cpu_access(1'b0, 16'hFE04, 16'h0, 1'b1, 16'h0000, "dsr_busy", 1);
        cpu_access(1'b0, 16'hFE06, 16'h0, 1'b1, 16'h0000, "ddr_read_zero", 1);
        Video_Ready = 1'b1;
        @(negedge Clk);
        Video_Ready = 1'b0;
        check("video_valid_cleared", Video_Valid, 1'b0);
        cpu_access(1'b0, 16'hFE04, 16'h0, 1'b1, 16'h8000, "dsr_free", 1);

        // Held request is serviced exactly once.
        kb_push(8'h55);
        kb_push(8'h66);
        base = mem_r_seen;
        exp_q.push_back('{1'b1, 16'h0055, "kbdr_held"});
        @(negedge Clk);
        MIO_EN = 1'b1; R_W = 1'b0; Address = 16'hFE02;
        repeat (10) @(negedge Clk);
        MIO_EN = 1'b0;
        repeat (2) @(negedge Clk);
        check("held_mem_r_count", mem_r_seen - base, 1);
        cpu_access(1'b0, 16'hFE02, 16'h0, 1'b1, 16'h0066, "kbdr_after_held", 1);

        // Reset during an SRAM write aborts it.
        @(negedge Clk);
        MIO_EN = 1'b1; R_W = 1'b1; Address = 16'h3000; Data_FromCPU = 16'hDEAD;
        @(posedge Clk); #1;
        check("abort_we_active", SRAM_WE_N, 1'b0);
        @(negedge Clk);
        Reset = 1'b1;
        base = mem_r_seen;
        @(posedge Clk); #1;
        check("abort_we_n_high", SRAM_WE_N, 1'b1);
        check("abort_ce_n_high", SRAM_CE_N, 1'b1);
        check("abort_mem_r_low", MEM_R, 1'b0);
        @(negedge Clk);
        MIO_EN = 1'b0; R_W = 1'b0;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        repeat (4) @(negedge Clk);
        check("abort_no_mem_r", mem_r_seen - base, 0);

        // Interrupt enable and KB_INT.
`ifdef KB_INTERRUPT_EN
        kbsr_ie_exp = 16'hC000;
        kb_int_exp  = 1'b1;
`else
        kbsr_ie_exp = 16'h8000;
        kb_int_exp  = 1'b0;
`endif
        cpu_access(1'b1, 16'hFE00, 16'h4000, 1'b0, 16'h0, "kbsr_wr_ie", 1);
        kb_push(8'h7A);
        repeat (3) @(negedge Clk);
        check("kb_int_pending", KB_INT, kb_int_exp);
        cpu_access(1'b0, 16'hFE00, 16'h0, 1'b1, kbsr_ie_exp, "kbsr_ie_readback", 1);
        cpu_access(1'b0, 16'hFE02, 16'h0, 1'b1, 16'h007A, "kbdr_int_byte", 1);
        repeat (2) @(negedge Clk);
        check("kb_int_cleared", KB_INT, 1'b0);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mmio_memory_controller.md
Name: mmio_memory_controller

Overview:
Parametrised successor to the eLC-3 memory control unit. It sits between the CPU memory interface (MAR/MDR, MIO_EN, R_W) and the external 1M x 16 SRAM, and decodes a memory-mapped I/O page holding keyboard and display registers. Compared with the previous generation, it adds:
- a request/ready handshake (MEM_R);
- configurable SRAM wait states;
- a keyboard receive FIFO with overrun flag;
- a valid/ready display output channel.

Parameters:
DATA_W, 16, CPU and SRAM data width
ADDR_W, 16, CPU address width
SRAM_ADDR_W, 20, SRAM address width; upper bits zero-extended
WAIT_STATES, 1, extra SRAM cycles per access (0..7)
KB_FIFO_DEPTH, 8, keyboard FIFO entries (power of 2, >=2)
IO_BASE, 16'hFE00, base of I/O page; KBSR=+0, KBDR=+2, DSR=+4, DDR=+6

Ports:
Clk  in  1  system clock; all state on rising edge
Reset  in  1  synchronous, active-high reset
MIO_EN  in  1  CPU memory request; held until MEM_R
R_W  in  1  1=write, 0=read; held with MIO_EN
Address  in  ADDR_W  CPU address; held with MIO_EN
Data_FromCPU  in  DATA_W  write data
Data_ToCPU  out  DATA_W  read data; valid in MEM_R cycle
MEM_R  out  1  one-cycle access-complete pulse
KB_Valid  in  1  keyboard byte strobe (one cycle per byte)
KB_Data  in  8  keyboard ASCII byte
Data_ToVideo  out  DATA_W  DDR contents
Video_Valid  out  1  DDR holds unconsumed character
Video_Ready  in  1  video consumer accepts character
KB_INT  out  1  keyboard interrupt request
SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_LB_N, SRAM_UB_N  out  1 each  SRAM controls, active-low
SRAM_ADDR  out  SRAM_ADDR_W  SRAM address
SRAM_DQ  inout  DATA_W  SRAM data bus

Behaviour:
- Reset values:
  - FSM=IDLE.
  - MEM_R=0, Data_ToCPU=0, Video_Valid=0, Data_ToVideo=0, KB_INT=0.
  - All SRAM_*_N=1; SRAM_DQ high-Z.
  - FIFO empty; KBSR=0; DDR=0.
  - Reset mid-access aborts the access; no MEM_R is issued.
- FSM states:
  - IDLE:
    - Accept a request when MIO_EN=1 and the rearm flag is set.
    - Address in IO_BASE..IO_BASE+6 (even) -> IO. Any other address -> SRAM_ACC.
    - Undefined I/O offsets (odd, or above +6) go to SRAM.
  - IO: one cycle; perform the register op; MEM_R=1; next state IDLE.
  - SRAM_ACC: held for WAIT_STATES+1 cycles, counted by a 3-bit counter.
    - CE_N=0, LB_N=0, UB_N=0 throughout.
    - Read: OE_N=0; DQ captured on the final cycle.
    - Write: WE_N=0; DQ driven with Data_FromCPU.
  - DONE: MEM_R=1; Data_ToCPU holds the captured word; next state IDLE.
  - SRAM_ADDR = zero-extended Address, registered at accept.
- Latency, with accept at cycle T:
  - I/O: MEM_R at T+1.
  - SRAM: MEM_R at T+WAIT_STATES+2.
- Rearm rule:
  - The rearm flag clears on MEM_R and sets when MIO_EN is sampled 0.
  - A held MIO_EN is never serviced twice.
- Keyboard FIFO:
  - KB_Valid pushes {8'h00, KB_Data}.
  - On push while full: the byte is dropped and KBSR[0] (overrun) is set, sticky.
- KBSR:
  - [15] = FIFO not empty (read-only).
  - [14] = interrupt enable, writable.
  - [0] = overrun; a write of any value clears it.
  - Other bits read 0.
- KBDR read: returns the FIFO head and pops it. If empty, returns 0 with no pop.
- Simultaneous push and pop: both occur; count unchanged; the full check uses the pre-pop count, so a push while full with a simultaneous pop is accepted.
- DSR: [15] = ~Video_Valid; other bits 0; writes ignored.
- DDR write:
  - If Video_Valid=0: load DDR, set Video_Valid.
  - Else: the write is dropped (MEM_R still issued).
  - Video_Valid clears on a cycle with Video_Valid and Video_Ready both 1.
  - A DDR write in that same cycle is accepted.
- Reads of DDR return 0.
- Width rule: DATA_W>16 zero-extends the I/O registers; the bit positions above are fixed.

Optional Feature:
- Macro KB_INTERRUPT_EN.
- Defined: KB_INT = KBSR[14] & KBSR[15], registered with one cycle of lag.
- Undefined: KB_INT tied 0 and KBSR[14] reads 0 (writes ignored).

Test Plan:
- SRAM write then read of Address 16'h3000 data 16'hBEEF with WAIT_STATES=1 -> WE_N low 2 cycles, MEM_R at T+3, read returns 16'hBEEF, SRAM_ADDR=20'h03000.
- Push 'A','B' (8'h41, 8'h42), read KBSR then KBDR twice -> 16'h8000, 16'h0041, 16'h0042, then KBSR=16'h0000.
- Push 9 bytes into the 8-deep FIFO -> KBSR=16'h8001; write KBSR -> bit 0 cleared; 8 reads return the first 8 bytes in order.
- Write DDR=16'h0058 with Video_Ready=0, then write 16'h0059 -> Data_ToVideo stays 16'h0058, DSR=16'h0000; pulse Video_Ready -> DSR=16'h8000.
- Hold MIO_EN high for 10 cycles on a KBDR read -> exactly one MEM_R and one pop.
- Assert Reset during SRAM_ACC write -> WE_N=1 and DQ high-Z next cycle, no MEM_R; with KB_INTERRUPT_EN, write KBSR=16'h4000 and push a byte -> KB_INT=1.
